stage_3_fixed_to_float: RTL and testbench

// - Return-path counterpart of the stage-1 float-to-CORDIC conditioning stage in final_adder.
// - Takes two signed fixed-point CORDIC results and converts each to IEEE-754 single precision.
// - Both channels run in parallel. Uses the same start/done/working handshake as stage 1.
// - Output feeds the final combine stage, which pairs it with the stage-1 half/square values.

---
 rtl/final_adder_pkg.sv | 43 ++++
 rtl/fixed_to_float_part.sv | 80 ++++++++
 rtl/stage_3_fixed_to_float.sv | 124 ++++++++++++
 tb/tb_stage_3_fixed_to_float.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/final_adder_pkg.sv
// Shared constants, state encodings and the float packing helper for the
// final_adder return path (CORDIC fixed point back to IEEE-754 single).
// Latency: n/a (package). Backpressure: n/a.
package final_adder_pkg;

  localparam int FLT_DATA_WIDTH    = 32;  // only 32 is supported
  localparam int CORDIC_DATA_WIDTH = 22;  // Q2.20 two's complement
  localparam int FRAC_BITS         = 20;
  localparam int FLT_BIAS          = 127;
  localparam int MANT_WIDTH        = 23;
  localparam int CNT_WIDTH         = 5;   // normalisation shifts, max 21

  typedef logic [1:0] state_t;

  // Per-channel part states
  localparam state_t IDLE = 2'b00;
  localparam state_t NORM = 2'b01;
  localparam state_t PACK = 2'b10;
  localparam state_t DONE = 2'b11;
  // Top-level join state shares the NORM encoding
  localparam state_t WAIT = 2'b01;

  // Biased exponent of a magnitude whose MSB is already set (zero shifts).
  localparam int EXP_TOP = FLT_BIAS + (CORDIC_DATA_WIDTH - 1) - FRAC_BITS;

  // Build the float word from a normalised magnitude. Zero maps to +0.0,
  // dropping the sign. The hidden bit is mag[MSB]; the rest fills the
  // mantissa exactly, so no rounding is needed.
  function automatic logic [FLT_DATA_WIDTH-1:0] pack_float(
    input logic                         sign,
    input logic [CORDIC_DATA_WIDTH-1:0] mag,
    input logic [CNT_WIDTH-1:0]         cnt
  );
    logic [7:0] exp;
    exp = 8'(EXP_TOP) - {3'b000, cnt};
    if (mag == '0) begin
      return '0;
    end
    return {sign, exp, mag[CORDIC_DATA_WIDTH-2:0],
            {(MANT_WIDTH - (CORDIC_DATA_WIDTH - 1)){1'b0}}};
  endfunction

endpackage

// File: rtl/fixed_to_float_part.sv
// One-channel Q2.20 to float converter: sign/magnitude, shift-normalise, pack.
// Latency: 3 + shifts enabled cycles from start to done (done is a 1-cycle flag).
// Backpressure: none; start only sampled in IDLE, clk_en low freezes everything.
// Ports: clk, rst (async active-low), clk_en, start, x (fixed in),
//        flt (float out, held until next PACK), done, working (not IDLE).
module fixed_to_float_part
  import final_adder_pkg::*;
(
  input  logic                         clk,
  input  logic                         clk_en,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CORDIC_DATA_WIDTH-1:0] x,
  output logic [FLT_DATA_WIDTH-1:0]    flt,
  output logic                         done,
  output logic                         working
);

  state_t                       state_q, state_d;
  logic                         sign_q, sign_d;
  logic [CORDIC_DATA_WIDTH-1:0] mag_q, mag_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [FLT_DATA_WIDTH-1:0]    flt_q, flt_d;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    flt_d   = flt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = x[CORDIC_DATA_WIDTH-1];
          // -2^21 negates to itself, which read unsigned is exactly 2^21
          mag_d   = x[CORDIC_DATA_WIDTH-1] ? (~x + CORDIC_DATA_WIDTH'(1)) : x;
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0 || mag_q[CORDIC_DATA_WIDTH-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      PACK: begin
        flt_d   = pack_float(sign_q, mag_q, cnt_q);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      cnt_q   <= '0;
      flt_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
    end
  end

  assign flt     = flt_q;
  assign done    = (state_q == DONE);
  assign working = (state_q != IDLE);

endmodule

// File: rtl/stage_3_fixed_to_float.sv
// Two-channel fixed-to-float stage: runs two parts in parallel and joins them.
// Latency: 4 + max(shifts_one, shifts_two) enabled cycles (4..25), done 1 cycle.
// Backpressure: start ignored unless IDLE; clk_en low holds all state and outputs.
// Ports: clk, rst (async active-low), clk_en, start, fix_one/fix_two (Q2.20 in),
//        flt_one/flt_two (float out, held until next done), done, working.
module stage_3_fixed_to_float
  import final_adder_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [CORDIC_DATA_WIDTH-1:0] fix_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] fix_two,
  output logic [FLT_DATA_WIDTH-1:0]    flt_one,
  output logic [FLT_DATA_WIDTH-1:0]    flt_two,
  output logic                         done,
  output logic                         working
);

  state_t                    state_q, state_d;
  logic                      flag_one_q, flag_one_d, flag_two_q, flag_two_d;
  logic [FLT_DATA_WIDTH-1:0] res_one_q, res_one_d, res_two_q, res_two_d;
  logic [FLT_DATA_WIDTH-1:0] flt_one_q, flt_one_d, flt_two_q, flt_two_d;

  logic                      part_start;
  logic                      p_done_one, p_done_two, p_wk_one, p_wk_two;
  logic [FLT_DATA_WIDTH-1:0] p_flt_one, p_flt_two;
  logic                      got_one, got_two;

  // Parts only see start while the join is idle, so a start during the
  // DONE cycle cannot kick off a channel on its own.
  assign part_start = start && (state_q == IDLE) && !p_wk_one && !p_wk_two;

  fixed_to_float_part first (
    .clk     (clk),
    .clk_en  (clk_en),
    .rst     (rst),
    .start   (part_start),
    .x       (fix_one),
    .flt     (p_flt_one),
    .done    (p_done_one),
    .working (p_wk_one)
  );

  fixed_to_float_part second (
    .clk     (clk),
    .clk_en  (clk_en),
    .rst     (rst),
    .start   (part_start),
    .x       (fix_two),
    .flt     (p_flt_two),
    .done    (p_done_two),
    .working (p_wk_two)
  );

  // A channel counts as finished if it finished earlier or finishes now.
  assign got_one = flag_one_q || p_done_one;
  assign got_two = flag_two_q || p_done_two;

  always_comb begin
    state_d    = state_q;
    flag_one_d = flag_one_q;
    flag_two_d = flag_two_q;
    res_one_d  = res_one_q;
    res_two_d  = res_two_q;
    flt_one_d  = flt_one_q;
    flt_two_d  = flt_two_q;
    case (state_q)
      IDLE: begin
        if (part_start) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (p_done_one) begin
          res_one_d  = p_flt_one;
          flag_one_d = 1'b1;
        end
        if (p_done_two) begin
          res_two_d  = p_flt_two;
          flag_two_d = 1'b1;
        end
        if (got_one && got_two) begin
          flt_one_d  = p_done_one ? p_flt_one : res_one_q;
          flt_two_d  = p_done_two ? p_flt_two : res_two_q;
          flag_one_d = 1'b0;
          flag_two_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      flag_one_q <= 1'b0;
      flag_two_q <= 1'b0;
      res_one_q  <= '0;
      res_two_q  <= '0;
      flt_one_q  <= '0;
      flt_two_q  <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      flag_one_q <= flag_one_d;
      flag_two_q <= flag_two_d;
      res_one_q  <= res_one_d;
      res_two_q  <= res_two_d;
      flt_one_q  <= flt_one_d;
      flt_two_q  <= flt_two_d;
    end
  end

  assign flt_one = flt_one_q;
  assign flt_two = flt_two_q;
  assign done    = (state_q == DONE);
  assign working = (state_q != IDLE);

endmodule

// File: tb/tb_stage_3_fixed_to_float.sv
// Bench for stage_3_fixed_to_float: directed cases plus randomized conversions
// checked against an arithmetic reference (abs value, leading-one position).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_stage_3_fixed_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [21:0] fix_one, fix_two;
  logic [31:0] flt_one, flt_two;
  logic        done, working;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_3_fixed_to_float dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .start   (start),
    .fix_one (fix_one),
    .fix_two (fix_two),
    .flt_one (flt_one),
    .flt_two (flt_two),
    .done    (done),
    .working (working)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int mag_of(input logic [21:0] fx);
    int v;
    v = $signed(fx);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int msb_of(input int m);
    int e;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return e;
  endfunction

  // value = fx * 2^-20; float = (-1)^s * 2^e * (1 + frac)
  function automatic logic [31:0] ref_flt(input logic [21:0] fx);
    int m, e;
    logic [7:0]  ex;
    logic [22:0] man;
    m = mag_of(fx);
    if (m == 0) return 32'h0;
    e   = msb_of(m);
    ex  = 8'(127 + e - 20);
    man = 23'((m - (1 << e)) << (23 - e));
    return {fx[21], ex, man};
  endfunction

  function automatic int ref_lat(input logic [21:0] a, input logic [21:0] b);
    int ca, cb;
    ca = (mag_of(a) == 0) ? 0 : 21 - msb_of(mag_of(a));
    cb = (mag_of(b) == 0) ? 0 : 21 - msb_of(mag_of(b));
    return 4 + ((ca > cb) ? ca : cb);
  endfunction

  function automatic logic [21:0] rnd_fix();
    logic [21:0] v;
    v = 22'($urandom) >> $urandom_range(0, 21);
    if ($urandom_range(0, 1) == 1) v = -v;
    if ($urandom_range(0, 7) == 0) v = '0;
    return v;
  endfunction

  // mode 0: clk_en always 1; 1: alternating; 2: random.
  // Latency counts enabled edges from the accepting edge to done high.
  task automatic convert(input logic [21:0] a, input logic [21:0] b, input int mode,
                         input bit extra_start, input string tag);
    int lat;
    bit seen, wk_ok;
    @(negedge clk);
    fix_one = a; fix_two = b; start = 1'b1; clk_en = 1'b1;
    lat = 1; seen = 1'b0; wk_ok = 1'b1;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!working) wk_ok = 1'b0;
        start   = extra_start && (cyc == 1);
        fix_one = 22'($urandom);
        fix_two = 22'($urandom);
        case (mode)
          0:       clk_en = 1'b1;
          1:       clk_en = ~clk_en;
          default: clk_en = 1'($urandom);
        endcase
        lat = lat + int'(clk_en);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_flt_one"}, flt_one, ref_flt(a));
    chk({tag, "_flt_two"}, flt_two, ref_flt(b));
    chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(a, b)));
    chk({tag, "_working"}, 32'(wk_ok && working), 32'd1);
    if (mode != 0) begin
      clk_en = 1'b0;
      @(negedge clk);
      chk({tag, "_done_hold"}, 32'(done), 32'd1);
    end
    clk_en = 1'b1;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(working), 32'd0);
    chk({tag, "_flt_keep"}, flt_one, ref_flt(a));
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; start = 1'b0; fix_one = '0; fix_two = '0;
    repeat (2) @(negedge clk);
    chk("reset_flt_one", flt_one, 32'h0);
    chk("reset_flt_two", flt_two, 32'h0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_working", 32'(working), 32'd0);
    rst = 1'b1;

    convert(22'h100000, 22'h080000, 0, 1'b0, "c1");
    convert(22'h300000, 22'h200000, 0, 1'b0, "c2");
    convert(22'h000000, 22'h000001, 0, 1'b0, "c3");
    convert(22'h100000, 22'h080000, 1, 1'b1, "c4");

    // Reset in the middle of a long conversion
    @(negedge clk);
    fix_one = 22'h000000; fix_two = 22'h000001; start = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_flt_one", flt_one, 32'h0);
    chk("rst_flt_two", flt_two, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_working", 32'(working), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    convert(22'h100000, 22'h080000, 0, 1'b0, "c5");

    // Start held high across two conversions
    @(negedge clk);
    fix_one = 22'h0C0000; fix_two = 22'h3FFFFF; start = 1'b1; clk_en = 1'b1;
    wait_done("b2b_a");
    chk("b2b_a_flt_one", flt_one, ref_flt(22'h0C0000));
    chk("b2b_a_flt_two", flt_two, ref_flt(22'h3FFFFF));
    fix_one = 22'h2ABCDE; fix_two = 22'h012345;
    @(negedge clk);
    chk("b2b_gap_working", 32'(working), 32'd0);
    chk("b2b_gap_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b_restart", 32'(working), 32'd1);
    wait_done("b2b_b");
    chk("b2b_b_flt_one", flt_one, ref_flt(22'h2ABCDE));
    chk("b2b_b_flt_two", flt_two, ref_flt(22'h012345));
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      convert(rnd_fix(), rnd_fix(), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
